// File: rtl/permute_controller.sv
// Sequencing FSM for the lane-permutation datapath: matrix read, per-lane remap
// load with counter supervision, and write-back, repeated for a batch of blocks.
module permute_controller #(
    parameter int LANES    = 25,
    parameter int CNT_W    = 32,
    parameter int BLK_W    = 8,
    parameter int WD_SLACK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [BLK_W-1:0] numBlocks,
    input  logic [CNT_W-1:0] cnt,
    output logic             dpRst,
    output logic             readData,
    output logic             ldn,
    output logic             enC,
    output logic             writeToFile,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BLK_W-1:0] blockIdx
);

    localparam int WD_MAX = LANES + WD_SLACK;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0]         WD_LIMIT  = WD_W'(WD_MAX);
    localparam logic [WD_W-1:0]         WD_ONE    = WD_W'(1);
    localparam logic [WD_W-1:0]         WD_ZERO   = WD_W'(0);
    localparam logic [BLK_W-1:0]        BLK_ONE   = BLK_W'(1);
    localparam logic [BLK_W-1:0]        BLK_ZERO  = BLK_W'(0);
    localparam logic signed [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
    localparam logic signed [CNT_W-1:0] ZERO_LANE = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_READ    = 3'd2,
        ST_PERMUTE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    state_t                  state_r;
    state_t                  next_norm_s;
    state_t                  state_next_s;
    logic [BLK_W-1:0]        count_r;
    logic [BLK_W-1:0]        blk_r;
    logic [WD_W-1:0]         wd_r;
    logic                    err_r;
    logic signed [CNT_W-1:0] cnt_s;
    logic                    last_lane_s;
    logic                    out_of_range_s;
    logic                    wd_expire_s;
    logic                    last_blk_s;
    logic                    start_ok_s;

    assign cnt_s          = $signed(cnt);
    assign last_lane_s    = (cnt_s == LAST_LANE);
    assign out_of_range_s = (cnt_s < ZERO_LANE) || (cnt_s > LAST_LANE);
    // The watchdog counts PERMUTE cycles already spent; this is the last allowed one.
    assign wd_expire_s    = ((wd_r + WD_ONE) == WD_LIMIT);
    assign last_blk_s     = (blk_r == (count_r - BLK_ONE));
    assign start_ok_s     = (state_r == ST_IDLE) && start;

    // Next-state selection ignoring abort.
    always_comb begin
        next_norm_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (numBlocks == BLK_ZERO) begin
                        next_norm_s = ST_DONE;
                    end else begin
                        next_norm_s = ST_INIT;
                    end
                end else begin
                    next_norm_s = ST_IDLE;
                end
            end
            ST_INIT:  next_norm_s = ST_READ;
            ST_READ:  next_norm_s = ST_PERMUTE;
            ST_PERMUTE: begin
                if (last_lane_s) begin
                    next_norm_s = ST_WRITE;
                end else if (out_of_range_s) begin
                    next_norm_s = ST_ERROR;
                end else if (wd_expire_s) begin
                    next_norm_s = ST_ERROR;
                end else begin
                    next_norm_s = ST_PERMUTE;
                end
            end
            ST_WRITE: next_norm_s = ST_NEXT;
            ST_NEXT: begin
                if (last_blk_s) begin
                    next_norm_s = ST_DONE;
                end else begin
                    next_norm_s = ST_INIT;
                end
            end
            ST_DONE:  next_norm_s = ST_IDLE;
            ST_ERROR: next_norm_s = ST_IDLE;
            default:  next_norm_s = ST_IDLE;
        endcase
    end

    // Abort outranks every transition, including error detection.
    assign state_next_s = (abort && (state_r != ST_IDLE)) ? ST_IDLE : next_norm_s;

    // Moore strobe decode; enC additionally stops on the final lane.
    always_comb begin
        dpRst       = 1'b0;
        readData    = 1'b0;
        ldn         = 1'b0;
        enC         = 1'b0;
        writeToFile = 1'b0;
        done        = 1'b0;
        case (state_r)
            ST_INIT:    dpRst       = 1'b1;
            ST_READ:    readData    = 1'b1;
            ST_PERMUTE: begin
                ldn = 1'b1;
                enC = ~last_lane_s;
            end
            ST_WRITE:   writeToFile = 1'b1;
            ST_DONE:    done        = 1'b1;
            default:    done        = 1'b0;
        endcase
    end

    assign busy     = (state_r != ST_IDLE);
    assign err      = err_r;
    assign blockIdx = blk_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Batch bookkeeping: latched block count, block index, watchdog and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= BLK_ZERO;
            blk_r   <= BLK_ZERO;
            wd_r    <= WD_ZERO;
            err_r   <= 1'b0;
        end else begin
            if (start_ok_s) begin
                count_r <= numBlocks;
            end else begin
                count_r <= count_r;
            end

            if (start_ok_s) begin
                blk_r <= BLK_ZERO;
            end else if ((state_r == ST_NEXT) && (state_next_s == ST_INIT)) begin
                blk_r <= blk_r + BLK_ONE;
            end else begin
                blk_r <= blk_r;
            end

            if (state_r == ST_READ) begin
                wd_r <= WD_ZERO;
            end else if (state_r == ST_PERMUTE) begin
                wd_r <= wd_r + WD_ONE;
            end else begin
                wd_r <= wd_r;
            end

            if (start_ok_s) begin
                err_r <= 1'b0;
            end else if (state_next_s == ST_ERROR) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_permute_controller.sv
// Randomized bench for permute_controller: a cycle-indexed timing model derived from
// the block schedule (LANES+4 cycles per block) is compared every cycle.
module tb_permute_controller;

    localparam int LANES = 25;
    localparam int P     = LANES + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  numBlocks = 8'd0;
    logic [31:0] cnt;
    logic        dpRst, readData, ldn, enC, writeToFile, busy, done, err;
    logic [7:0]  blockIdx;

    logic [31:0] cnt_m;
    int          mode = 0;            // 0 healthy, 1 stuck at 3, 2 forced value
    logic [31:0] force_val = 32'd30;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int t_rel  = 0;

    logic e_dp, e_rd, e_ld, e_en, e_wf, e_busy, e_done, e_err;
    int   e_blk;
    int   idle_blk = 0;
    int   idle_err = 0;
    int   cur_n = 0, cur_abort = 0, cur_err = 0;

    int dp_q[$];
    int n_rd, n_ld, n_en, n_wf, n_done;
    int first_rd, first_ld, last_ld, first_en, last_en, first_wf, first_done, first_err;

    always #5 clk = ~clk;

    permute_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .numBlocks(numBlocks),
        .cnt(cnt), .dpRst(dpRst), .readData(readData), .ldn(ldn), .enC(enC),
        .writeToFile(writeToFile), .busy(busy), .done(done), .err(err), .blockIdx(blockIdx)
    );

    // Datapath lane counter stand-in
    always @(posedge clk or posedge rst) begin
        if (rst)        cnt_m <= 32'd0;
        else if (dpRst) cnt_m <= 32'd0;
        else if (enC)   cnt_m <= cnt_m + 32'd1;
    end
    assign cnt = (mode == 1) ? 32'd3 : (mode == 2) ? force_val : cnt_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0d expected %0d", name, t_rel, act, exp);
        end
    endtask

    task automatic exp_idle();
        e_dp = 0; e_rd = 0; e_ld = 0; e_en = 0; e_wf = 0; e_busy = 0; e_done = 0;
        e_err = idle_err[0];
        e_blk = idle_blk;
    endtask

    // Expected outputs in cycle t after a start sampled in cycle 0
    task automatic exp_at(input int t);
        int total;
        total = (cur_n == 0) ? 1 : cur_n * P + 1;
        e_dp = 0; e_rd = 0; e_ld = 0; e_en = 0; e_wf = 0; e_busy = 0; e_done = 0; e_err = 0;
        e_blk = 0;
        if (cur_abort != 0 && t > cur_abort) begin
            e_blk = (cur_n == 0) ? 0 : (cur_abort - 1) / P;
        end else if (cur_err != 0) begin
            e_err  = (t >= cur_err);
            e_busy = (t <= cur_err);
            e_dp   = (t == 1);
            e_rd   = (t == 2);
            e_ld   = (t >= 3 && t < cur_err);
            e_en   = e_ld;
        end else if (t < total) begin
            int p;
            p      = (t - 1) % P;
            e_busy = 1;
            e_blk  = (t - 1) / P;
            e_dp   = (p == 0);
            e_rd   = (p == 1);
            e_ld   = (p >= 2 && p <= LANES + 1);
            e_en   = (p >= 2 && p <= LANES);
            e_wf   = (p == LANES + 2);
        end else begin
            e_done = (t == total);
            e_busy = (t == total);
            e_blk  = (cur_n == 0) ? 0 : cur_n - 1;
        end
    endtask

    task automatic clear_log();
        dp_q.delete();
        n_rd = 0; n_ld = 0; n_en = 0; n_wf = 0; n_done = 0;
        first_rd = -1; first_ld = -1; last_ld = -1; first_en = -1; last_en = -1;
        first_wf = -1; first_done = -1; first_err = -1;
    endtask

    // Per-cycle comparison against the model, plus event log for literal pins
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dpRst", dpRst, e_dp);
            chk("readData", readData, e_rd);
            chk("ldn", ldn, e_ld);
            chk("enC", enC, e_en);
            chk("writeToFile", writeToFile, e_wf);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("blockIdx", blockIdx, e_blk);
            if (dpRst) dp_q.push_back(t_rel);
            if (readData) begin n_rd++; if (first_rd < 0) first_rd = t_rel; end
            if (ldn) begin n_ld++; if (first_ld < 0) first_ld = t_rel; last_ld = t_rel; end
            if (enC) begin n_en++; if (first_en < 0) first_en = t_rel; last_en = t_rel; end
            if (writeToFile) begin n_wf++; if (first_wf < 0) first_wf = t_rel; end
            if (done) begin n_done++; if (first_done < 0) first_done = t_rel; end
            if (err && first_err < 0) first_err = t_rel;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            numBlocks = 8'($urandom);
            exp_idle();
            step();
        end
        abort = 1'b0;
    endtask

    task automatic run_batch(input int n, input int ab, input int ea, input int fa,
                             input bit stk, input bit noise, input int rst_at);
        int total, end_busy, last;
        cur_n = n; cur_abort = ab; cur_err = ea;
        total    = (n == 0) ? 1 : n * P + 1;
        end_busy = (ab != 0) ? ab : (ea != 0) ? ea : total;
        last     = end_busy + 3;
        clear_log();
        mode = stk ? 1 : 0;
        start = 1'b1; abort = 1'b0; numBlocks = 8'(n);
        t_rel = 0;
        exp_idle();
        step();
        for (int t = 1; t <= last; t++) begin
            start = (noise && t <= end_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise && t <= end_busy) numBlocks = 8'($urandom);
            abort = (t == ab);
            if (fa != 0 && t == fa) mode = 2;
            if (ea != 0 && t >= ea) mode = 0;
            t_rel = t;
            exp_at(t);
            if (rst_at != 0 && t == rst_at) begin
                chk("wtf_before_rst", writeToFile, 1);
                chk_en = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_dpRst", dpRst, 0);
                chk("rst_readData", readData, 0);
                chk("rst_ldn", ldn, 0);
                chk("rst_enC", enC, 0);
                chk("rst_writeToFile", writeToFile, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_blockIdx", blockIdx, 0);
                step();
                rst = 1'b0;
                start = 1'b0;
                idle_blk = 0; idle_err = 0;
                exp_idle();
                chk_en = 1'b1;
                break;
            end
            step();
        end
        idle_blk = e_blk;
        idle_err = e_err;
        start = 1'b0; abort = 1'b0; mode = 0;
    endtask

    initial begin
        int n, ab, ea, fa, total;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_blockIdx", blockIdx, 0);
        rst = 1'b0;
        exp_idle();
        chk_en = 1'b1;
        idle(2);

        // Single block with start noise while busy
        run_batch(1, 0, 0, 0, 0, 1, 0);
        chk("single_dpRst_cnt", dp_q.size(), 1);
        if (dp_q.size() > 0) chk("single_dpRst_at", dp_q[0], 1);
        chk("single_read_at", first_rd, 2);
        chk("single_ldn_first", first_ld, 3);
        chk("single_ldn_last", last_ld, 27);
        chk("single_enC_first", first_en, 3);
        chk("single_enC_last", last_en, 26);
        chk("single_wtf_at", first_wf, 28);
        chk("single_done_at", first_done, 30);
        chk("single_done_cnt", n_done, 1);
        idle(3);

        // Batch of three
        run_batch(3, 0, 0, 0, 0, 1, 0);
        chk("batch_dpRst_cnt", dp_q.size(), 3);
        if (dp_q.size() == 3) begin
            chk("batch_dpRst0", dp_q[0], 1);
            chk("batch_dpRst1", dp_q[1], 30);
            chk("batch_dpRst2", dp_q[2], 59);
        end
        chk("batch_done_at", first_done, 88);
        chk("batch_done_cnt", n_done, 1);
        idle(2);

        // Zero blocks
        run_batch(0, 0, 0, 0, 0, 0, 0);
        chk("zero_done_at", first_done, 1);
        chk("zero_dpRst_cnt", dp_q.size(), 0);
        chk("zero_read_cnt", n_rd, 0);
        chk("zero_ldn_cnt", n_ld, 0);
        chk("zero_wtf_cnt", n_wf, 0);
        idle(2);

        // Stuck counter trips the watchdog, then a healthy batch clears err
        run_batch(1, 0, 3 + LANES + 2, 0, 1, 0, 0);
        chk("stuck_ldn_cnt", n_ld, 27);
        chk("stuck_ldn_last", last_ld, 29);
        chk("stuck_wtf_cnt", n_wf, 0);
        chk("stuck_done_cnt", n_done, 0);
        idle(4);
        run_batch(1, 0, 0, 0, 0, 0, 0);
        chk("recover_done_at", first_done, 30);
        idle(2);

        // Out-of-range counter value
        force_val = 32'd30;
        run_batch(1, 0, 11, 10, 0, 0, 0);
        chk("oor_err_at", first_err, 11);
        chk("oor_wtf_cnt", n_wf, 0);
        idle(2);

        // Abort in PERMUTE of a two-block batch
        run_batch(2, 15, 0, 0, 0, 1, 0);
        chk("abort_done_cnt", n_done, 0);
        chk("abort_wtf_cnt", n_wf, 0);
        idle(2);

        // Randomized batches with aborts, faults and busy-time noise
        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(0, 4);
            ab = 0; ea = 0; fa = 0;
            total = (n == 0) ? 1 : n * P + 1;
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(1, total - 1);
                if ((ab - 1) % P == P - 1) ab = ab - 1;
            end else if (n > 0 && $urandom_range(0, 3) == 0) begin
                fa = $urandom_range(3, 26);
                ea = fa + 1;
                case ($urandom_range(0, 2))
                    0: force_val = 32'd30;
                    1: force_val = 32'hFFFF_FFFF;
                    default: force_val = 32'd25;
                endcase
            end
            run_batch(n, ab, ea, fa, 0, 1, 0);
            idle($urandom_range(1, 5));
        end

        // Asynchronous reset during WRITE, then a normal batch
        run_batch(1, 0, 0, 0, 0, 0, 28);
        idle(2);
        run_batch(2, 0, 0, 0, 0, 1, 0);
        chk("post_rst_done_at", first_done, 59);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
